// File: rtl/touch_pkg.sv
// Shared types and defaults for the touch pressure/position filter.
package touch_pkg;

  localparam int COORD_W = 9;

  localparam logic [COORD_W-1:0] Z_PRESS_DEF   = 9'd64;
  localparam logic [COORD_W-1:0] Z_RELEASE_DEF = 9'd32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DOWN  = 2'd1,
    TOUCH = 2'd2,
    UP    = 2'd3
  } touch_state_t;

endpackage

// File: rtl/touch_avg.sv
// Windowed x/y accumulator: sums 2^AVG_LOG2 samples, then publishes the truncated mean.
module touch_avg
  import touch_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic               cclk,
  input  logic               rstb,
  input  logic               clr,
  input  logic               add,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               done,
  output logic [COORD_W-1:0] res_x,
  output logic [COORD_W-1:0] res_y
);

  localparam int ACC_W = COORD_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] WINDOW = CNT_W'(1 << AVG_LOG2);

  logic [ACC_W-1:0]   sum_x_reg, sum_y_reg;
  logic [ACC_W-1:0]   sum_x_next, sum_y_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               done_reg;
  logic [COORD_W-1:0] res_x_reg, res_y_reg;

  always_comb begin
    sum_x_next = sum_x_reg + ACC_W'(x);
    sum_y_next = sum_y_reg + ACC_W'(y);
    count_next = count_reg + CNT_W'(1);
  end

  // The completing sample is folded in on the same edge that publishes the mean.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      sum_x_reg <= '0;
      sum_y_reg <= '0;
      count_reg <= '0;
      done_reg  <= 1'b0;
      res_x_reg <= '0;
      res_y_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      if (clr) begin
        sum_x_reg <= '0;
        sum_y_reg <= '0;
        count_reg <= '0;
      end else if (add) begin
        if (count_next == WINDOW) begin
          res_x_reg <= sum_x_next[ACC_W-1:AVG_LOG2];
          res_y_reg <= sum_y_next[ACC_W-1:AVG_LOG2];
          done_reg  <= 1'b1;
          sum_x_reg <= '0;
          sum_y_reg <= '0;
          count_reg <= '0;
        end else begin
          sum_x_reg <= sum_x_next;
          sum_y_reg <= sum_y_next;
          count_reg <= count_next;
        end
      end
    end
  end

  assign done  = done_reg;
  assign res_x = res_x_reg;
  assign res_y = res_y_reg;

endmodule

// File: rtl/touch_filter.sv
// Debounced touch detector with hysteresis, press/release events and averaged position.
module touch_filter
  import touch_pkg::*;
#(
  parameter int                 AVG_LOG2  = 2,
  parameter logic [COORD_W-1:0] Z_PRESS   = Z_PRESS_DEF,
  parameter logic [COORD_W-1:0] Z_RELEASE = Z_RELEASE_DEF,
  parameter int                 DEBOUNCE  = 3
) (
  input  logic               cclk,
  input  logic               rstb,
  input  logic               sample_valid,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic [COORD_W-1:0] z_in,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               pos_valid,
  output logic               touching,
  output logic               press_evt,
  output logic               release_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  touch_state_t     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             touching_reg, touching_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             avg_clr, avg_add;
  logic             z_press, z_release;

  assign z_press   = (z_in >= Z_PRESS);
  assign z_release = (z_in < Z_RELEASE);
  assign cnt_inc   = cnt_reg + ONE_C;

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      touching_reg <= 1'b0;
      press_reg    <= 1'b0;
      release_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      touching_reg <= touching_next;
      press_reg    <= press_next;
      release_reg  <= release_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    touching_next = touching_reg;
    press_next    = 1'b0;
    release_next  = 1'b0;
    avg_clr       = 1'b0;
    avg_add       = 1'b0;

    if (sample_valid) begin
      case (state_reg)
        IDLE: begin
          if (z_press) begin
            if (ONE_C == DEB_C) begin
              state_next    = TOUCH;
              cnt_next      = '0;
              touching_next = 1'b1;
              press_next    = 1'b1;
              avg_clr       = 1'b1;
            end else begin
              state_next = DOWN;
              cnt_next   = ONE_C;
            end
          end
        end

        DOWN: begin
          if (z_press) begin
            if (cnt_inc == DEB_C) begin
              state_next    = TOUCH;
              cnt_next      = '0;
              touching_next = 1'b1;
              press_next    = 1'b1;
              avg_clr       = 1'b1;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end

        // Samples between the thresholds still count as touching and feed the window.
        TOUCH: begin
          if (z_release) begin
            if (ONE_C == DEB_C) begin
              state_next    = IDLE;
              cnt_next      = '0;
              touching_next = 1'b0;
              release_next  = 1'b1;
              avg_clr       = 1'b1;
            end else begin
              state_next = UP;
              cnt_next   = ONE_C;
            end
          end else begin
            avg_add = 1'b1;
          end
        end

        UP: begin
          if (z_release) begin
            if (cnt_inc == DEB_C) begin
              state_next    = IDLE;
              cnt_next      = '0;
              touching_next = 1'b0;
              release_next  = 1'b1;
              avg_clr       = 1'b1;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            state_next = TOUCH;
            cnt_next   = '0;
            avg_add    = 1'b1;
          end
        end

        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  touch_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .cclk  (cclk),
    .rstb  (rstb),
    .clr   (avg_clr),
    .add   (avg_add),
    .x     (x_in),
    .y     (y_in),
    .done  (pos_valid),
    .res_x (pos_x),
    .res_y (pos_y)
  );

  assign touching    = touching_reg;
  assign press_evt   = press_reg;
  assign release_evt = release_reg;

endmodule
